// File: rtl/RS5_pkg.sv
// Shared types for the register-bank write path: destination index width and
// the write request carried by the long-latency result buffer.
package RS5_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;
endpackage

// File: rtl/regbank_wb_fifo.sv
// Small circular buffer for long-latency results waiting for the write port.
// Head is presented combinationally; a push is never visible before the next cycle.
module regbank_wb_fifo
  import RS5_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic    clk,
  input  logic    reset_n,
  input  logic    push_i,
  input  wb_req_t push_req_i,
  input  logic    pop_i,
  output wb_req_t head_o,
  output logic    full_o,
  output logic    empty_o
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  wb_req_t          mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_req_i;
  end
endmodule

// File: rtl/regbank_write_arbiter.sv
// Arbitrates the single register-bank write port between pipeline writeback and
// buffered long-latency results, and tracks in-flight long-latency destinations.
module regbank_write_arbiter
  import RS5_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wb_valid_i,
  input  logic [REG_ADDR_W-1:0] wb_rd_i,
  input  logic [XLEN-1:0]       wb_data_i,
  output logic                  wb_ready_o,
  input  logic                  lu_valid_i,
  input  logic [REG_ADDR_W-1:0] lu_rd_i,
  input  logic [XLEN-1:0]       lu_data_i,
  output logic                  lu_ready_o,
  input  logic                  issue_valid_i,
  input  logic [REG_ADDR_W-1:0] issue_rd_i,
  output logic                  issue_ready_o,
  input  logic [REG_ADDR_W-1:0] rs1_i,
  input  logic [REG_ADDR_W-1:0] rs2_i,
  output logic                  hazard_o,
  output logic                  rf_enable_o,
  output logic [REG_ADDR_W-1:0] rf_rd_o,
  output logic [XLEN-1:0]       rf_data_o
);
  localparam int NREGS = 1 << REG_ADDR_W;
  localparam int SW    = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  wb_req_t          head, lu_req;
  logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [SW-1:0]    starve_q, starve_d;
  logic [NREGS-1:0] pend_q, pend_d;
  logic             starve, wb_live, grant_fifo, grant_wb, issue_set;

  assign lu_req    = '{rd: lu_rd_i, data: lu_data_i};
  assign lu_ready_o = !fifo_full;
  assign fifo_push = lu_valid_i && lu_ready_o;

  regbank_wb_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push_i    (fifo_push),
    .push_req_i(lu_req),
    .pop_i     (fifo_pop),
    .head_o    (head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // A writeback to x0 never needs the port, so it yields to the FIFO for free.
  assign starve     = (starve_q >= STARVE_LIM);
  assign wb_live    = wb_valid_i && (wb_rd_i != '0);
  assign grant_fifo = !fifo_empty && (starve || !wb_live);
  assign grant_wb   = !grant_fifo && wb_live;
  assign fifo_pop   = grant_fifo;
  assign wb_ready_o = !(starve && !fifo_empty) || !wb_live;

  always_comb begin
    rf_enable_o = 1'b0;
    rf_rd_o     = '0;
    rf_data_o   = '0;
    if (grant_fifo) begin
      rf_enable_o = reset_n && (head.rd != '0);
      rf_rd_o     = head.rd;
      rf_data_o   = head.data;
    end else if (grant_wb) begin
      rf_enable_o = reset_n;
      rf_rd_o     = wb_rd_i;
      rf_data_o   = wb_data_i;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (fifo_pop || fifo_empty) starve_d = '0;
    else if (!starve)           starve_d = starve_q + SW'(1);
  end

  assign issue_ready_o = !pend_q[issue_rd_i] || (issue_rd_i == '0);
  assign issue_set     = issue_valid_i && issue_ready_o && (issue_rd_i != '0);
  assign hazard_o      = ((rs1_i != '0) && pend_q[rs1_i]) ||
                         ((rs2_i != '0) && pend_q[rs2_i]);

  // Set is applied after clear so a same-index collision leaves the bit set.
  always_comb begin
    pend_d = pend_q;
    if (fifo_pop)  pend_d[head.rd]    = 1'b0;
    if (issue_set) pend_d[issue_rd_i] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_q <= '0;
      pend_q   <= '0;
    end else begin
      starve_q <= starve_d;
      pend_q   <= pend_d;
    end
  end

  a_wb_not_pending: assert property (@(posedge clk) disable iff (!reset_n)
    (wb_valid_i && wb_rd_i != '0) |-> !pend_q[wb_rd_i]);
  a_lu_pending: assert property (@(posedge clk) disable iff (!reset_n)
    (fifo_push && lu_rd_i != '0) |-> pend_q[lu_rd_i]);
endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Random plus directed traffic against a queue/array reference model; a monitor
// compares each cycle's port outputs with the expectation the driver queued.
module tb_regbank_write_arbiter;
  import RS5_pkg::*;
  localparam int DEPTH = 2;
  localparam int SMAX  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  logic wb_valid_i, lu_valid_i, issue_valid_i;
  logic [4:0] wb_rd_i, lu_rd_i, issue_rd_i, rs1_i, rs2_i;
  logic [31:0] wb_data_i, lu_data_i;
  logic wb_ready_o, lu_ready_o, issue_ready_o, hazard_o, rf_enable_o;
  logic [4:0] rf_rd_o;
  logic [31:0] rf_data_o;

  regbank_write_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset_n(reset_n),
    .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i), .wb_ready_o(wb_ready_o),
    .lu_valid_i(lu_valid_i), .lu_rd_i(lu_rd_i), .lu_data_i(lu_data_i), .lu_ready_o(lu_ready_o),
    .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i), .issue_ready_o(issue_ready_o),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .hazard_o(hazard_o),
    .rf_enable_o(rf_enable_o), .rf_rd_o(rf_rd_o), .rf_data_o(rf_data_o)
  );

  typedef struct {
    bit en; logic [4:0] rd; logic [31:0] data;
    bit wb_rdy, lu_rdy, is_rdy, haz;
  } exp_t;

  exp_t        exp_q[$];
  wb_req_t     mq[$];
  bit          mpend[32];
  int          mstarve;
  logic [4:0]  outst[$];
  logic [31:0] rf_model[32], rf_dut[32];
  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete(); outst.delete(); mstarve = 0;
    foreach (mpend[i]) mpend[i] = 0;
  endtask

  // One clock cycle: drive inputs, derive expected outputs from the rules, advance model.
  task automatic cyc(input bit wbv, input logic [4:0] wbrd, input logic [31:0] wbd,
                     input bit luv, input logic [4:0] lurd, input logic [31:0] lud,
                     input bit iv, input logic [4:0] ird,
                     input logic [4:0] r1, input logic [4:0] r2);
    exp_t e;
    bit ne, st, gf, gw, wl;
    wb_req_t h;
    @(negedge clk);
    wb_valid_i = wbv; wb_rd_i = wbrd; wb_data_i = wbd;
    lu_valid_i = luv; lu_rd_i = lurd; lu_data_i = lud;
    issue_valid_i = iv; issue_rd_i = ird; rs1_i = r1; rs2_i = r2;
    ne = (mq.size() > 0);
    st = (mstarve >= SMAX);
    wl = wbv && (wbrd != 0);
    gf = ne && (st || !wl);
    gw = !gf && wl;
    e.en = 0; e.rd = 0; e.data = 0;
    if (gf && mq[0].rd != 0) begin e.en = 1; e.rd = mq[0].rd; e.data = mq[0].data; end
    if (gw) begin e.en = 1; e.rd = wbrd; e.data = wbd; end
    e.wb_rdy = !(st && ne) || !wl;
    e.lu_rdy = (mq.size() < DEPTH);
    e.is_rdy = !mpend[ird] || (ird == 0);
    e.haz    = (r1 != 0 && mpend[r1]) || (r2 != 0 && mpend[r2]);
    exp_q.push_back(e);
    if (e.en) rf_model[e.rd] = e.data;
    if (gf) begin h = mq.pop_front(); mpend[h.rd] = 0; end
    if (luv && e.lu_rdy) begin
      mq.push_back('{rd: lurd, data: lud});
      foreach (outst[i]) if (outst[i] == lurd) begin outst.delete(i); break; end
    end
    if (gf) mstarve = 0;
    else if (!ne) mstarve = 0;
    else if (mstarve < SMAX) mstarve++;
    if (iv && e.is_rdy && ird != 0) begin mpend[ird] = 1; outst.push_back(ird); end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk); #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rf_enable", 32'(rf_enable_o), 32'(e.en));
        if (e.en) begin
          chk("rf_rd", 32'(rf_rd_o), 32'(e.rd));
          chk("rf_data", rf_data_o, e.data);
        end
        if (rf_enable_o === 1'b1) rf_dut[rf_rd_o] = rf_data_o;
        chk("wb_ready", 32'(wb_ready_o), 32'(e.wb_rdy));
        chk("lu_ready", 32'(lu_ready_o), 32'(e.lu_rdy));
        chk("issue_ready", 32'(issue_ready_o), 32'(e.is_rdy));
        chk("hazard", 32'(hazard_o), 32'(e.haz));
      end
    end
  end

  initial begin : driver
    bit wbv, luv, iv;
    logic [4:0] wbrd, lurd, ird;
    int guard;
    foreach (rf_model[i]) begin rf_model[i] = 0; rf_dut[i] = 0; end
    model_reset();
    reset_n = 0;
    wb_valid_i = 1; wb_rd_i = 5; wb_data_i = 32'h1;
    lu_valid_i = 0; lu_rd_i = 0; lu_data_i = 0;
    issue_valid_i = 0; issue_rd_i = 0; rs1_i = 0; rs2_i = 0;
    #1;
    chk("reset rf_enable", 32'(rf_enable_o), 0);
    chk("reset wb_ready", 32'(wb_ready_o), 1);
    chk("reset lu_ready", 32'(lu_ready_o), 1);
    chk("reset issue_ready", 32'(issue_ready_o), 1);
    chk("reset hazard", 32'(hazard_o), 0);
    @(negedge clk); reset_n = 1;

    // Plain pipeline write, then read back.
    cyc(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    chk("x5 readback", rf_dut[5], 32'hDEADBEEF);

    // RAW/WAW on an issued long-latency destination.
    cyc(0, 0, 0, 0, 0, 0, 1, 7, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
    cyc(0, 0, 0, 1, 7, 32'h1234, 0, 0, 7, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 7, 7);

    // Starvation: pipeline keeps rd=3 busy while x9 waits.
    cyc(0, 0, 0, 0, 0, 0, 1, 9, 0, 0);
    cyc(1, 3, 32'h33, 1, 9, 32'h99, 0, 0, 9, 0);
    for (int i = 0; i < 7; i++) cyc(1, 3, 32'h300 + i, 0, 0, 0, 0, 0, 9, 0);

    // Full FIFO back-pressure: third result held until a slot frees.
    cyc(0, 0, 0, 0, 0, 0, 1, 10, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 11, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 12, 0, 0);
    cyc(1, 3, 32'hA0, 1, 10, 32'h10, 0, 0, 0, 0);
    cyc(1, 3, 32'hA1, 1, 11, 32'h11, 0, 0, 0, 0);
    guard = 0;
    while (12 inside {outst} && guard < 12) begin
      cyc(1, 3, 32'hB0 + guard, 1, 12, 32'h12, 0, 0, 12, 0);
      guard++;
    end
    chk("third lu accepted", 32'(guard < 12), 1);
    idle(4);

    // x0 pipeline write yields the port to the FIFO head.
    cyc(0, 0, 0, 0, 0, 0, 1, 4, 0, 0);
    cyc(1, 3, 32'hC0, 1, 4, 32'h44, 0, 0, 0, 0);
    cyc(1, 0, 32'hC1, 0, 0, 0, 0, 0, 4, 0);
    idle(1);

    // Reset mid-cycle with two buffered results pending on x4 and x9.
    cyc(0, 0, 0, 0, 0, 0, 1, 4, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 9, 0, 0);
    cyc(1, 3, 32'hD0, 1, 4, 32'h4444, 0, 0, 0, 0);
    cyc(1, 3, 32'hD1, 1, 9, 32'h9999, 0, 0, 0, 0);
    cyc(1, 3, 32'hD2, 0, 0, 0, 0, 0, 4, 9);
    #3 reset_n = 0;
    #1;
    chk("midreset rf_enable", 32'(rf_enable_o), 0);
    chk("midreset lu_ready", 32'(lu_ready_o), 1);
    chk("midreset hazard", 32'(hazard_o), 0);
    chk("midreset issue_ready", 32'(issue_ready_o), 1);
    model_reset();
    @(negedge clk); reset_n = 1;
    idle(4);

    // Randomized legal traffic.
    for (int c = 0; c < 3000; c++) begin
      wbv = ($urandom_range(0, 1) == 1);
      wbrd = 5'($urandom_range(0, 31));
      if (mpend[wbrd]) wbrd = 0;
      luv = (outst.size() > 0) && ($urandom_range(0, 9) < 4);
      lurd = (outst.size() > 0) ? outst[$urandom_range(0, outst.size() - 1)] : 5'd0;
      iv = ($urandom_range(0, 9) < 3);
      ird = 5'($urandom_range(0, 31));
      cyc(wbv, wbrd, $urandom, luv, lurd, $urandom, iv, ird,
          5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end
    guard = 0;
    while (outst.size() > 0 && guard < 200) begin
      cyc(0, 0, 0, 1, outst[0], $urandom, 0, 0, 0, 0);
      guard++;
    end
    idle(6);
    @(negedge clk); #4;
    chk("scoreboard drained", 32'(exp_q.size()), 0);
    for (int r = 0; r < 32; r++) chk("regfile", rf_dut[r], rf_model[r]);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
